// File: rtl/tt_capture.sv
`default_nettype none
// ============================================================================
// Module   : tt_capture
// Purpose  : Sequential truth-table extractor for a small N_IN-input,
//            single-output combinational gate. Walks the stimulus through
//            every input combination. After each new vector it waits SETTLE
//            cycles, samples the gate output, and packs the results into a
//            2**N_IN-bit truth-table word.
// Revision : 1.0  initial release
//
// Parameters
//   N_IN    number of gate inputs (1..6); table width TW = 2**N_IN
//   SETTLE  wait cycles after each new stimulus before sampling (0..255)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a capture (honoured only when idle)
//   abort      in   cancel a capture in progress / clear tt_valid when idle
//   stim       out  registered stimulus; stim[k] drives gate input k
//   dut_out    in   gate output, sampled directly (SETTLE covers propagation)
//   busy       out  high from accepted start until done or abort
//   done       out  one-cycle pulse when the table is complete
//   tt         out  truth table; bit i = dut_out observed with stim == i
//   tt_valid   out  high while tt holds a complete capture
//
// Optional feature (macro TT_CMP_EN)
//   tt_expect  in   reference table, sampled when the last vector is taken
//   match      out  1 when the completed table equals tt_expect
//   mismatch   out  per-bit difference between completed table and tt_expect
// ============================================================================
module tt_capture #(
    parameter int  N_IN   = 4,
    parameter int  SETTLE = 2,
    localparam int TW     = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] stim,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [TW-1:0]   tt,
    output logic            tt_valid
`ifdef TT_CMP_EN
    ,
    input  logic [TW-1:0]   tt_expect,
    output logic            match,
    output logic [TW-1:0]   mismatch
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0]    SETTLE_C = 8'(SETTLE);
    // idx carries one spare bit so the terminal vector never wraps to zero.
    localparam logic [N_IN:0] LAST_IDX = {1'b0, {N_IN{1'b1}}};

    state_t            state_q;
    logic [N_IN-1:0]   stim_q;
    logic              busy_q;
    logic              done_q;
    logic [TW-1:0]     tt_q;
    logic              tt_valid_q;
    logic [N_IN:0]     idx_q;
    logic [7:0]        cnt_q;
    logic [TW-1:0]     tt_d;
`ifdef TT_CMP_EN
    logic              match_q;
    logic [TW-1:0]     mismatch_q;
`endif

    // Table with the current sample folded in; on the terminal vector this
    // is the completed word, so the comparison can use it in the same edge.
    always_comb begin
        tt_d                     = tt_q;
        tt_d[idx_q[N_IN-1:0]]    = dut_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            stim_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_q       <= '0;
            tt_valid_q <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
`ifdef TT_CMP_EN
            match_q    <= 1'b0;
            mismatch_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (abort) begin
                        tt_valid_q <= 1'b0;
`ifdef TT_CMP_EN
                        match_q    <= 1'b0;
                        mismatch_q <= '0;
`endif
                    end else if (start) begin
                        state_q    <= S_WAIT;
                        stim_q     <= '0;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        tt_valid_q <= 1'b0;
                        tt_q       <= '0;
`ifdef TT_CMP_EN
                        match_q    <= 1'b0;
                        mismatch_q <= '0;
`endif
                    end
                end

                S_WAIT, S_DONE: begin
                    if (abort) begin
                        // Partial table in tt is deliberately left in place.
                        state_q    <= S_IDLE;
                        stim_q     <= '0;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b0;
                        tt_valid_q <= 1'b0;
`ifdef TT_CMP_EN
                        match_q    <= 1'b0;
                        mismatch_q <= '0;
`endif
                    end else if (state_q == S_DONE) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q < SETTLE_C) begin
                        cnt_q <= cnt_q + 8'd1;
                    end else begin
                        tt_q <= tt_d;
                        if (idx_q != LAST_IDX) begin
                            idx_q  <= idx_q + 1'b1;
                            stim_q <= idx_q[N_IN-1:0] + 1'b1;
                            cnt_q  <= '0;
                        end else begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            tt_valid_q <= 1'b1;
`ifdef TT_CMP_EN
                            mismatch_q <= tt_d ^ tt_expect;
                            match_q    <= (tt_d == tt_expect);
`endif
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stim     = stim_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tt       = tt_q;
    assign tt_valid = tt_valid_q;
`ifdef TT_CMP_EN
    assign match    = match_q;
    assign mismatch = mismatch_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tt_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_capture
// Purpose  : Self-checking bench for tt_capture. Two instances: one with the
//            default settle time, one with SETTLE=0. Each gate is modelled as
//            a lookup of a 16-bit function word indexed by the stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_tt_capture;

    localparam int N_IN = 4;
    localparam int TW   = 16;
    localparam int SA   = 2;
    localparam int SB   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic          start_a = 1'b0, abort_a = 1'b0;
    logic          start_b = 1'b0, abort_b = 1'b0;
    logic [3:0]    stim_a, stim_b;
    logic          busy_a, busy_b, done_a, done_b, tv_a, tv_b;
    logic [15:0]   tt_a, tt_b;
    logic [15:0]   c_a = 16'h0000;
    logic [15:0]   c_b = 16'h0000;
    logic          dut_out_a, dut_out_b;
`ifdef TT_CMP_EN
    logic [15:0]   exp_a = 16'h6847;
    logic [15:0]   exp_b = 16'h6847;
    logic          match_a, match_b;
    logic [15:0]   mism_a, mism_b;
`endif

    int errors = 0;
    int checks = 0;

    // Gate model: output is the function word's bit selected by the inputs.
    assign dut_out_a = c_a[stim_a];
    assign dut_out_b = c_b[stim_b];

    always #5 clk = ~clk;

    tt_capture #(.N_IN(N_IN), .SETTLE(SA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .stim(stim_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .tt(tt_a), .tt_valid(tv_a)
`ifdef TT_CMP_EN
        , .tt_expect(exp_a), .match(match_a), .mismatch(mism_a)
`endif
    );

    tt_capture #(.N_IN(N_IN), .SETTLE(SB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .stim(stim_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .tt(tt_b), .tt_valid(tv_b)
`ifdef TT_CMP_EN
        , .tt_expect(exp_b), .match(match_b), .mismatch(mism_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic g_busy(bit b);  return b ? busy_b : busy_a; endfunction
    function automatic logic g_done(bit b);  return b ? done_b : done_a; endfunction
    function automatic logic g_tv(bit b);    return b ? tv_b   : tv_a;   endfunction
    function automatic logic [15:0] g_tt(bit b);  return b ? tt_b : tt_a; endfunction
    function automatic logic [3:0]  g_stim(bit b); return b ? stim_b : stim_a; endfunction

    task automatic set_start(bit b, logic v); if (b) start_b = v; else start_a = v; endtask
    task automatic set_abort(bit b, logic v); if (b) abort_b = v; else abort_a = v; endtask
    task automatic set_word(bit b, logic [15:0] w); if (b) c_b = w; else c_a = w; endtask

    // Full capture; optionally hammers start while busy.
    task automatic run_capture(input bit b, input logic [15:0] word, input bit noise);
        int s     = b ? SB : SA;
        int total = TW * (s + 1);
        logic [3:0] seen[$];
        int done_cnt = 0;
        int done_k   = -1;
        int bad      = 0;
        set_word(b, word);
        set_start(b, 1'b1);
        step();
        set_start(b, 1'b0);
        check("start_busy", g_busy(b), 1);
        check("start_tt_clear", g_tt(b), 0);
        check("start_tv_clear", g_tv(b), 0);
        for (int k = 0; k <= total + 3; k++) begin
            if (g_busy(b)) seen.push_back(g_stim(b));
            if (g_done(b)) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            set_start(b, (noise && g_busy(b)) ? 1'($urandom_range(0, 1)) : 1'b0);
            step();
        end
        set_start(b, 1'b0);
        check("done_pulses", done_cnt, 1);
        check("done_cycle", done_k + 1, total + 1);
        check("tt_word", g_tt(b), word);
        check("tt_valid_hold", g_tv(b), 1);
        check("busy_after", g_busy(b), 0);
        check("stim_len", seen.size(), total);
        foreach (seen[i]) if (seen[i] != 4'(i / (s + 1))) bad++;
        check("stim_order", bad, 0);
`ifdef TT_CMP_EN
        check("cmp_match", b ? match_b : match_a, (word == 16'h6847) ? 1 : 0);
        check("cmp_mismatch", b ? mism_b : mism_a, word ^ 16'h6847);
`endif
    endtask

    // Capture cancelled by abort sampled at edge A after the start edge.
    task automatic run_abort(input bit b, input logic [15:0] word, input int a);
        int s = b ? SB : SA;
        int n = (a - 1) / (s + 1);
        int dn = 0;
        logic [15:0] mask = 16'((32'd1 << n) - 1);
        set_word(b, word);
        set_start(b, 1'b1);
        step();
        set_start(b, 1'b0);
        for (int k = 0; k < a - 1; k++) step();
        set_abort(b, 1'b1);
        step();
        set_abort(b, 1'b0);
        check("abort_busy", g_busy(b), 0);
        check("abort_tv", g_tv(b), 0);
        check("abort_stim", g_stim(b), 0);
        check("abort_tt_partial", g_tt(b), word & mask);
        for (int k = 0; k < 6; k++) begin
            if (g_done(b) || g_busy(b)) dn++;
            step();
        end
        check("abort_quiet", dn, 0);
    endtask

    task automatic wait_done(input bit b, input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (g_done(b)) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        int dn;

        // Reset state
        repeat (3) step();
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_stim", stim_a, 0);
        check("rst_tt", tt_a, 0);
        check("rst_tv", tv_a, 0);
        #2 rst_n = 1'b1;
        step();

        // Main function: reference word and table extremes
        run_capture(1'b0, 16'h6847, 1'b0);
        run_capture(1'b1, 16'h0000, 1'b0);
        run_capture(1'b1, 16'hFFFF, 1'b0);
        run_capture(1'b1, 16'hAAAA, 1'b0);
        for (int i = 0; i < 3; i++) run_capture(1'b1, 16'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) run_capture(1'b0, 16'($urandom), 1'b1);

        // Abort mid-capture, then a fresh capture
        run_abort(1'b0, 16'h6847, 20);
        run_capture(1'b0, 16'h6847, 1'b0);
        for (int i = 0; i < 3; i++)
            run_abort(1'b1, 16'($urandom), int'($urandom_range(1, TW * (SB + 1))));
        for (int i = 0; i < 2; i++)
            run_abort(1'b0, 16'($urandom), int'($urandom_range(1, TW * (SA + 1))));

        // Abort in idle clears tt_valid only
        run_capture(1'b0, 16'h1234, 1'b0);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("idle_abort_tv", tv_a, 0);
        check("idle_abort_tt", tt_a, 16'h1234);
        check("idle_abort_busy", busy_a, 0);

        // Start coincident with done is ignored; one cycle later it is taken
        c_a = 16'h6847;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done(1'b0, 100, found);
        check("wait_done_1", found, 1);
        start_a = 1'b1;
        step();
        check("start_at_done", busy_a, 0);
        step();
        check("start_after_done", busy_a, 1);
        start_a = 1'b0;
        wait_done(1'b0, 100, found);
        check("wait_done_2", found, 1);
        step();
        check("restart_tt", tt_a, 16'h6847);

        // Asynchronous reset between clock edges mid-capture
        c_a = 16'h6847;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_stim", stim_a, 0);
        check("arst_tt", tt_a, 0);
        check("arst_tv", tv_a, 0);
        check("arst_done", done_a, 0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (done_a || busy_a) dn++;
        end
        check("arst_quiet", dn, 0);

`ifdef TT_CMP_EN
        check("cmp_rst_match", match_a, 0);
        run_capture(1'b0, 16'h6846, 1'b0);
        run_capture(1'b0, 16'h6847, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_capture.md
Name: tt_capture

Overview:
- Sequential truth-table extractor for small combinational gate netlists in the ABC_designs flow.
- Drives every input combination into an attached N_IN-input, single-output gate, waits a settle interval, samples the output, and assembles the packed truth-table word. For a 4-input gate this is the 16-bit hex code the design is named by.
- Sits in the characterisation harness between the test sequencer and the device-under-test netlist; the inverse of the netlist, which maps a truth table to logic.

Parameters:
- N_IN, 4, number of DUT inputs; table width TW = 2**N_IN; legal 1..6.
- SETTLE, 2, wait cycles after each new stimulus before sampling; legal 0..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin capture; honoured only in IDLE.
- abort  input  1  cancel capture in progress.
- stim  output  N_IN  registered stimulus to DUT inputs; stim[k] drives DUT input _k.
- dut_out  input  1  DUT output.
- busy  output  1  high from accepted start until done pulse or abort.
- done  output  1  one-cycle pulse when tt is complete.
- tt  output  TW  captured truth table; bit i = dut_out observed with stim == i.
- tt_valid  output  1  high while tt holds a complete capture.

Behaviour:
- Reset (async assert, sync release): state=IDLE, stim=0, busy=0, done=0, tt=0, tt_valid=0, idx=0, cnt=0.
- States:
  - IDLE
    - start=1 -> WAIT; next cycle stim=0, idx=0, cnt=0, busy=1, tt_valid=0, tt cleared to 0.
  - WAIT
    - cnt<SETTLE: cnt++.
    - cnt==SETTLE: go to SAMPLE behaviour in the same cycle.
    - With SETTLE=0, every vector samples in its first cycle.
  - SAMPLE (at the cycle where cnt==SETTLE)
    - tt[idx] <= dut_out.
    - idx<TW-1: idx++, stim<=idx+1, cnt<=0, stay WAIT.
    - idx==TW-1: -> DONE.
  - DONE (one cycle)
    - done=1, busy=0, tt_valid=1 -> IDLE.
    - tt and tt_valid hold until next accepted start, abort or reset.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - done asserts exactly TW*(SETTLE+1)+1 cycles after the start-sampling edge (49 for defaults).
- Widths:
  - idx is N_IN+1 bits internally; no wrap on the terminal vector.
  - cnt is 8 bits.
  - stim never exceeds TW-1.
- Simultaneous events:
  - start while busy: ignored.
  - abort has priority over start and over sampling. abort in any non-IDLE state -> IDLE next cycle: busy=0, no done pulse, tt_valid=0, tt unchanged (partial), stim=0.
  - abort in IDLE: clears tt_valid only.
  - start and done in the same cycle: start ignored; the new capture is accepted one cycle later in IDLE.
- Reset mid-capture: immediate return to reset values; no done pulse.
- dut_out is sampled directly, with no synchroniser. SETTLE must cover DUT propagation.

Optional Feature:
- Macro: TT_CMP_EN.
- When defined, adds:
  - input tt_expect [TW]
  - output match [1]
  - output mismatch [TW]
- On the DONE cycle: mismatch <= tt_final ^ tt_expect, and match <= (mismatch == 0). tt_final is the completed word including the last sample.
- Both hold with tt_valid, are reset to 0, and clear on start/abort.
- tt_expect is sampled only on the DONE cycle.
- When not defined, none of these ports or logic exist; all other behaviour is identical.

Test Plan:
- Defaults; bench model dut_out = C[stim] with C=16'h6847; pulse start -> done at cycle 49, tt=16'h6847, tt_valid=1, busy low after.
- Captures with C=16'h0000, 16'hFFFF, 16'hAAAA (dut_out = stim[0]) at SETTLE=0 -> tt equals C, done at cycle 17, stim visits 0..15 in order.
- Assert abort at cycle 20 of a capture -> busy=0 next cycle, no done pulse, tt_valid=0, stim=0; fresh start then yields correct tt=16'h6847.
- Pulse start repeatedly while busy -> single capture, single done pulse; start coincident with done is ignored, and start one cycle later is accepted.
- Drop rst_n asynchronously mid-capture (between clock edges) -> all outputs zero immediately; after release, IDLE; no spurious done.
- With TT_CMP_EN, tt_expect=16'h6847 and DUT C=16'h6846 -> match=0, mismatch=16'h0001; with C=16'h6847 -> match=1, mismatch=0.
